imem_loader: RTL and testbench

Program loader that writes the byte-addressed instruction memory from a byte stream, the write-side counterpart of the registered 32-bit instruction fetch port. Accepts a framed stream (sync byte, word count, little-endian instruction words), drives one byte write per accepted data byte into the 256-byte instruction store, and holds the CPU pipeline while loading. Sits between a host byte source (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory program loader: FSM states and frame constants.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_FIN  = 3'd4,
    ST_FAIL = 3'd5
  } state_e;

  // The loader takes stream bytes in every state except the two one-cycle exit states.
  function automatic logic accepts_bytes(state_e s);
    return !(s == ST_FIN || s == ST_FAIL);
  endfunction

  function automatic logic in_frame(state_e s);
    return accepts_bytes(s) && (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: host byte stream in, instruction-memory byte write port and status out.
// slave = loader side, master = host/memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses {0xA5, N, 4*N bytes} frames into byte writes of the instruction store.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ready_q, hold_q, done_q;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  assign accept = bus.in_valid && ready_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.in_data == SYNC_BYTE) begin
          state_d = ST_LEN;
          err_d   = 1'b0;
        end
      end

      ST_LEN: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = 8'h00;
`endif
          if (bus.in_data == 8'h00) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_FIN;
`endif
          end else if (int'(bus.in_data) > MAX_WORDS) begin
            state_d = ST_FAIL;
          end else begin
            // Counter holds the index of the last data byte, so zero marks the final write.
            cnt_d   = CNT_W'({bus.in_data, 2'b00} - 10'd1);
            addr_d  = BASE;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = bus.in_data;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ bus.in_data;
`endif
          if (cnt_q == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = (bus.in_data == chk_q) ? ST_FIN : ST_FAIL;
        end
      end
`endif

      ST_FIN:  state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_FAIL) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= BASE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= BASE;
      wdata_q <= 8'h00;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= 8'h00;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= accepts_bytes(state_d);
      hold_q  <= in_frame(state_d);
      done_q  <= (state_d == ST_FIN);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, hand-written corner sequences,
// and random frames against a stream-level reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int MAX_WORDS = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    logic [11:0][7:0] b;
    int               len;
    int               exp_writes;
    int               exp_done;
    logic             exp_err;
    int               exp_hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory stand-in and output monitor, sampled on the falling edge.
  wr_t        wr_log[$];
  int         done_cnt, hold_cyc, coinc_cnt;
  logic [7:0] tb_mem [256];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        wr_log.push_back({bus.mem_addr, bus.mem_wdata});
        tb_mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (bus.done) begin
        done_cnt++;
        if (bus.mem_we) coinc_cnt++;
      end
      if (bus.cpu_hold) hold_cyc++;
    end
  end

  task automatic clear_mon();
    wr_log.delete();
    done_cnt  = 0;
    hold_cyc  = 0;
    coinc_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready low for %0d cycles, expected high", waited);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: interprets a whole byte stream from the framing rules.
  wr_t        exp_log[$];
  int         exp_done;
  logic       exp_err;
  logic [7:0] ref_mem [256];

  task automatic model_stream(input bq_t s);
    int         i;
    int         n;
    int         a;
    logic [7:0] x;
    i = 0;
    exp_log.delete();
    exp_done = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC_BYTE) begin
        i++;
        continue;
      end
      i++;
      exp_err = 1'b0;
      if (i >= s.size()) break;
      n = int'(s[i]);
      i++;
      if (n > MAX_WORDS) begin
        exp_err = 1'b1;
        continue;
      end
      x = 8'h00;
      for (int k = 0; k < 4 * n && i < s.size(); k++) begin
        a = (BASE_ADDR + k) % (1 << ADDR_W);
        exp_log.push_back({a[ADDR_W-1:0], s[i]});
        ref_mem[a] = s[i];
        x = x ^ s[i];
        i++;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (i < s.size()) begin
        if (s[i] == x) exp_done++;
        else exp_err = 1'b1;
        i++;
      end
`else
      exp_done++;
`endif
    end
  endtask

  vec_t vecs[7];

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_mem_we",    32'(bus.mem_we),    0);
    check("rst_mem_addr",  32'(bus.mem_addr),  BASE_ADDR);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_cpu_hold",  32'(bus.cpu_hold),  0);
    check("rst_done",      32'(bus.done),      0);
    check("rst_err",       32'(bus.err),       0);
    rst_n = 1'b1;
    idle(2);
    check("idle_in_ready", 32'(bus.in_ready), 1);

    // Directed frames; byte 0 is the least-significant byte of b.
    vecs[0] = '{b: 96'h0000_0000_0000_00E8_0820_01A5, len: 6,  exp_writes: 4, exp_done: 1, exp_err: 1'b0, exp_hold: 5};
    vecs[1] = '{b: 96'h0000_0000_0000_0000_0000_A533, len: 3,  exp_writes: 0, exp_done: 1, exp_err: 1'b0, exp_hold: 1};
    vecs[2] = '{b: 96'h0000_0000_0000_0000_0000_41A5, len: 2,  exp_writes: 0, exp_done: 0, exp_err: 1'b1, exp_hold: 1};
    vecs[3] = '{b: 96'h0000_0000_0000_EFBE_ADDE_01A5, len: 6,  exp_writes: 4, exp_done: 1, exp_err: 1'b0, exp_hold: 5};
    vecs[4] = '{b: 96'h0000_0000_0000_0000_00A5_1200, len: 4,  exp_writes: 0, exp_done: 1, exp_err: 1'b0, exp_hold: 1};
    vecs[5] = '{b: 96'h0000_0000_0000_0000_0000_FFA5, len: 2,  exp_writes: 0, exp_done: 0, exp_err: 1'b1, exp_hold: 1};
    vecs[6] = '{b: 96'h0000_0807_0605_0403_0201_02A5, len: 10, exp_writes: 8, exp_done: 1, exp_err: 1'b0, exp_hold: 9};

    for (int v = 0; v < 7; v++) begin
      int         p;
      logic [7:0] x;
      p = 0;
      while (vecs[v].b[p] != SYNC_BYTE) p++;
      x = 8'h00;
      for (int k = p + 2; k < vecs[v].len; k++) x = x ^ vecs[v].b[k];
      clear_mon();
      for (int k = 0; k < vecs[v].len; k++) send_byte(vecs[v].b[k]);
      if (CHK_EXTRA != 0 && !vecs[v].exp_err) send_byte(x);
      idle(4);
      check($sformatf("v%0d_writes", v), 32'(wr_log.size()), 32'(vecs[v].exp_writes));
      for (int k = 0; k < vecs[v].exp_writes && k < wr_log.size(); k++)
        check($sformatf("v%0d_wr%0d", v, k), 32'(wr_log[k]),
              32'({8'(BASE_ADDR + k), vecs[v].b[p + 2 + k]}));
      check($sformatf("v%0d_done", v), 32'(done_cnt), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_hold", v), 32'(hold_cyc),
            32'(vecs[v].exp_hold + (vecs[v].exp_err ? 0 : CHK_EXTRA)));
      check($sformatf("v%0d_done_we", v), 32'(coinc_cnt),
            32'((vecs[v].exp_done > 0 && vecs[v].exp_writes > 0 && CHK_EXTRA == 0) ? 1 : 0));
      if (v == 0)
        check("fetch_word0", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h00E8_0820);
    end

    // Two-word frame with a one-cycle in_valid gap after every byte.
    begin
      bq_t        s;
      logic [7:0] x;
      s = '{8'hA5, 8'h02, 8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
      x = 8'h00;
      for (int k = 2; k < 10; k++) x = x ^ s[k];
      clear_mon();
      foreach (s[k]) begin
        send_byte(s[k]);
        idle(1);
      end
      if (CHK_EXTRA != 0) send_byte(x);
      idle(4);
      check("gap_writes", 32'(wr_log.size()), 8);
      for (int k = 0; k < 8 && k < wr_log.size(); k++)
        check($sformatf("gap_wr%0d", k), 32'(wr_log[k]), 32'({8'(BASE_ADDR + k), s[k + 2]}));
      check("gap_done", 32'(done_cnt), 1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    clear_mon();
    foreach (vecs[0].b[k]) if (k < 6) send_byte(vecs[0].b[k]);
    send_byte(8'hC0);
    idle(4);
    check("chk_good_done", 32'(done_cnt), 1);
    check("chk_good_err", 32'(bus.err), 0);
    clear_mon();
    foreach (vecs[0].b[k]) if (k < 6) send_byte(vecs[0].b[k]);
    send_byte(8'h00);
    idle(4);
    check("chk_bad_done", 32'(done_cnt), 0);
    check("chk_bad_err", 32'(bus.err), 1);
    check("chk_bad_writes", 32'(wr_log.size()), 4);
`endif

    // Reset after two data bytes, then a complete frame.
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_writes", 32'(wr_log.size()), 2);
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    check("mid_rst_mem_we", 32'(bus.mem_we), 0);
    check("mid_rst_mem_addr", 32'(bus.mem_addr), BASE_ADDR);
    check("mid_rst_cpu_hold", 32'(bus.cpu_hold), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    if (CHK_EXTRA != 0) send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    idle(4);
    check("post_rst_writes", 32'(wr_log.size()), 4);
    check("post_rst_done", 32'(done_cnt), 1);
    check("post_rst_fetch", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h7856_3412);

    // Random frames against the stream-level model.
    for (int a = 0; a < 256; a++) begin
      tb_mem[a]  = 8'h00;
      ref_mem[a] = 8'h00;
    end
    exp_err = 1'b0;
    for (int f = 0; f < 24; f++) begin
      bq_t        s;
      int         n;
      int         r;
      int         mism;
      logic [7:0] x;
      logic [7:0] j;
      s.delete();
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom_range(0, 255));
        s.push_back((j == SYNC_BYTE) ? 8'h5A : j);
      end
      s.push_back(SYNC_BYTE);
      r = $urandom_range(0, 9);
      if (r == 0) n = $urandom_range(MAX_WORDS + 1, 255);
      else if (r == 1) n = MAX_WORDS;
      else n = $urandom_range(0, 6);
      s.push_back(8'(n));
      if (n <= MAX_WORDS) begin
        x = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
          j = 8'($urandom_range(0, 255));
          s.push_back(j);
          x = x ^ j;
        end
        if (CHK_EXTRA != 0)
          s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
      end
      clear_mon();
      foreach (s[k]) begin
        send_byte(s[k]);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(4);
      model_stream(s);
      check($sformatf("rnd%0d_writes", f), 32'(wr_log.size()), 32'(exp_log.size()));
      mism = 0;
      for (int k = 0; k < wr_log.size() && k < exp_log.size(); k++)
        if (wr_log[k] !== exp_log[k]) mism++;
      check($sformatf("rnd%0d_wr_list", f), 32'(mism), 0);
      check($sformatf("rnd%0d_done", f), 32'(done_cnt), 32'(exp_done));
      check($sformatf("rnd%0d_err", f), 32'(bus.err), 32'(exp_err));
    end
    begin
      int mism;
      mism = 0;
      for (int a = 0; a < 256; a++) if (tb_mem[a] !== ref_mem[a]) mism++;
      check("rnd_mem_image", 32'(mism), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
